i2c_slave_regif: RTL
====================

// Module: i2c_slave_regif
// PURPOSE
//  I2C target (slave) that answers the i2c_master core on the same SCL/SDA bus.
//  Oversamples SCL/SDA on Clk, detects START/STOP, matches a fixed 7-bit address
//  and ACKs it. Write transfers: first data byte loads a register pointer; later
//  bytes go out as Reg_wr pulses. Read transfers return Reg_rdata at the pointer.
//  The pointer auto-increments after every data byte in both directions.
//  Used as the bus-functional target in master benches and as an on-chip slave.
// PARAMETERS
//  SLV_ADDR  7'h50  7-bit I2C address this target responds to
//  AWIDTH    3      register pointer width; wraps modulo 2**AWIDTH
// PORTS
//  Clk        in   1       system clock, >=16x SCL frequency
//  Rst        in   1       synchronous reset, active-high
//  Scl_i      in   1       SCL pad input (asynchronous)
//  Sda_i      in   1       SDA pad input (asynchronous)
//  Sda_oe     out  1       1 = pull SDA low (open drain), 0 = release
//  Reg_addr   out  AWIDTH  current register pointer
//  Reg_wdata  out  8       received data byte, valid while Reg_wr=1
//  Reg_wr     out  1       1-cycle write strobe to the register file
//  Reg_rdata  in   8       read data for Reg_addr (combinational from reg file)
//  Busy       out  1       bus busy: set on START, cleared on STOP
//  Addressed  out  1       address matched in the current transfer
// BEHAVIOUR
//  - Reset (Rst=1 at posedge Clk) sets Sda_oe=0, Reg_addr=0, Reg_wdata=0,
//    Reg_wr=0, Busy=0 and Addressed=0, and sets the FSM to IDLE. This holds
//    mid-transfer too; the pins are released within 1 cycle.
//  - Pins pass through a 2-FF synchronizer, then SCL/SDA edge detect. An internal
//    event occurs 2 Clk cycles after a pin change.
//  - START: SDA falls while SCL=1. STOP: SDA rises while SCL=1. Both are
//    recognised in every state, and both take priority over bit processing.
//    START or repeated START -> ADDR, bitcnt=0, Busy=1, Addressed=0.
//    STOP -> IDLE, Busy=0, Addressed=0, Sda_oe=0.
//  - Timing rule: sample SDA on SCL rise; change Sda_oe only on SCL fall.
//  - FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT.
//    ADDR: shift 8 bits MSB first. On the 8th SCL fall:
//      byte[7:1]==SLV_ADDR -> ADDR_ACK with Sda_oe=1 and Addressed=1;
//      otherwise -> WAIT with Sda_oe=0.
//    ADDR_ACK: on the SCL fall that ends the ACK bit, release SDA.
//      R/W=0 -> WR_BYTE with first=1.
//      R/W=1 -> RD_BYTE; load shreg=Reg_rdata and drive Sda_oe=~shreg[7].
//    WR_BYTE: shift 8 bits. On the 8th SCL fall -> WR_ACK with Sda_oe=1.
//      first=1 -> Reg_addr=byte[AWIDTH-1:0], first=0.
//      first=0 -> Reg_wdata=byte, Reg_wr=1 for exactly 1 cycle,
//      then Reg_addr+1 on the next cycle.
//    WR_ACK: release SDA on SCL fall -> WR_BYTE.
//    RD_BYTE: shift out on each SCL fall. After 8 bits, release SDA -> RD_ACK.
//      Reg_addr increments by 1 at the transition.
//    RD_ACK: sample the master ACK on SCL rise.
//      ACK (SDA=0): on SCL fall reload shreg from Reg_rdata -> RD_BYTE.
//      NACK: -> WAIT.
//    WAIT: Sda_oe=0; ignore SCL until START or STOP.
//  - Pointer wraps 2**AWIDTH-1 -> 0 with no flag. Read and write share the pointer.
//  - Reg_wr and the pointer increment never coincide with Rst. A STOP between the
//    8th SCL fall and the ACK still completes the Reg_wr already issued.
// CONFIGURATION
//  I2C_SLV_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the
//    synchronizer on both SCL and SDA. Pulses of 1 Clk are rejected and event
//    latency becomes 4 cycles.
//  Undefined: no filter; 2-cycle latency; a 1-cycle glitch is seen as an edge.
// TESTING
//  1 Write: START, 0xA0, 0x02, 0xA5, STOP.
//    -> 3 ACKs (Sda_oe=1 in each 9th bit).
//    -> one Reg_wr with Reg_addr=2, Reg_wdata=0xA5; then Reg_addr=3; Busy 1->0.
//  2 Miss: START, 0xA2, 0x11, STOP.
//    -> Sda_oe stays 0 throughout, Addressed=0, no Reg_wr, Busy=1 until STOP.
//  3 Read with wrap, Reg_rdata=Reg_addr*8'h11:
//    START, 0xA0, 0x07, rSTART, 0xA1, read 2 bytes (ACK then NACK), STOP.
//    -> master sees 0x77 then 0x00; Sda_oe=0 after the NACK; Reg_addr=1.
//  4 STOP after 4 bits of a WR_BYTE -> IDLE, Sda_oe=0, no Reg_wr, Busy=0.
//  5 Rst=1 for 1 cycle while driving a 0 read bit.
//    -> Sda_oe=0 the next cycle, all outputs at reset values.
//    -> next START+0xA0 is ACKed normally.
//  6 With I2C_SLV_GLITCH_FILTER_EN: 1-Clk SCL low glitch during RD_BYTE -> no shift.
//    Without the macro: the same glitch advances bitcnt by 1.

Source files
------------

// File: rtl/i2c_slave_regif.sv
// rtl/i2c_slave_regif.sv - I2C register-file target; define I2C_SLV_GLITCH_FILTER_EN for the 3-sample SCL/SDA filter
module i2c_slave_regif #(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         AWIDTH   = 3
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Scl_i,
   input  logic              Sda_i,
   output logic              Sda_oe,
   output logic [AWIDTH-1:0] Reg_addr,
   output logic [7:0]        Reg_wdata,
   output logic              Reg_wr,
   input  logic [7:0]        Reg_rdata,
   output logic              Busy,
   output logic              Addressed
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT
   } state_t;

   // Synchronizers are not reset so that a reset with the bus mid-bit
   // cannot fabricate a START/STOP from stale flop contents.
   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       w_scl;
   logic       w_sda;

   always_ff @(posedge Clk) begin
      r_scl_sync <= {r_scl_sync[0], Scl_i};
      r_sda_sync <= {r_sda_sync[0], Sda_i};
   end

`ifdef I2C_SLV_GLITCH_FILTER_EN
   logic [1:0] r_scl_hist;
   logic [1:0] r_sda_hist;
   logic       r_scl_flt;
   logic       r_sda_flt;

   always_ff @(posedge Clk) begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_flt  <= (r_scl_sync[1] & r_scl_hist[0]) | (r_scl_sync[1] & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_flt  <= (r_sda_sync[1] & r_sda_hist[0]) | (r_sda_sync[1] & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
   end

   assign w_scl = r_scl_flt;
   assign w_sda = r_sda_flt;
`else
   assign w_scl = r_scl_sync[1];
   assign w_sda = r_sda_sync[1];
`endif

   logic r_scl_q;
   logic r_sda_q;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   always_ff @(posedge Clk) begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
   end

   assign w_scl_rise = w_scl & ~r_scl_q;
   assign w_scl_fall = ~w_scl & r_scl_q;
   assign w_start    = r_sda_q & ~w_sda & w_scl & r_scl_q;
   assign w_stop     = ~r_sda_q & w_sda & w_scl & r_scl_q;

   state_t            r_state;
   logic [3:0]        r_bitcnt;
   logic [7:0]        r_shreg;
   logic              r_first;
   logic              r_rw;
   logic              r_rd_nack;
   logic              r_inc_pend;
   logic              r_sda_oe;
   logic [AWIDTH-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic              r_wr;
   logic              r_busy;
   logic              r_addressed;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= 4'd0;
         r_shreg     <= 8'd0;
         r_first     <= 1'b0;
         r_rw        <= 1'b0;
         r_rd_nack   <= 1'b0;
         r_inc_pend  <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 8'd0;
         r_wr        <= 1'b0;
         r_busy      <= 1'b0;
         r_addressed <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         // Post-write pointer bump lives outside the FSM so a STOP cannot cancel it.
         if (r_inc_pend) begin
            r_addr     <= r_addr + AWIDTH'(1);
            r_inc_pend <= 1'b0;
         end
         if (w_start) begin
            r_state     <= S_ADDR;
            r_bitcnt    <= 4'd0;
            r_busy      <= 1'b1;
            r_addressed <= 1'b0;
            r_sda_oe    <= 1'b0;
         end else if (w_stop) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_addressed <= 1'b0;
            r_sda_oe    <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR, S_WR_BYTE: begin
                  if (w_scl_rise) begin
                     r_shreg  <= {r_shreg[6:0], w_sda};
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                     r_bitcnt <= 4'd0;
                     if (r_state == S_ADDR) begin
                        if (r_shreg[7:1] == SLV_ADDR) begin
                           r_state     <= S_ADDR_ACK;
                           r_sda_oe    <= 1'b1;
                           r_addressed <= 1'b1;
                           r_rw        <= r_shreg[0];
                        end else begin
                           r_state  <= S_WAIT;
                           r_sda_oe <= 1'b0;
                        end
                     end else begin
                        r_state  <= S_WR_ACK;
                        r_sda_oe <= 1'b1;
                        if (r_first) begin
                           r_addr  <= r_shreg[AWIDTH-1:0];
                           r_first <= 1'b0;
                        end else begin
                           r_wdata    <= r_shreg;
                           r_wr       <= 1'b1;
                           r_inc_pend <= 1'b1;
                        end
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (r_rw) begin
                        r_state  <= S_RD_BYTE;
                        r_shreg  <= Reg_rdata;
                        r_sda_oe <= ~Reg_rdata[7];
                        r_bitcnt <= 4'd1;
                     end else begin
                        r_state  <= S_WR_BYTE;
                        r_first  <= 1'b1;
                        r_sda_oe <= 1'b0;
                        r_bitcnt <= 4'd0;
                     end
                  end
               end
               S_WR_ACK: begin
                  if (w_scl_fall) begin
                     r_state  <= S_WR_BYTE;
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= 4'd0;
                  end
               end
               S_RD_BYTE: begin
                  // r_bitcnt counts bits already placed on SDA.
                  if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        r_state  <= S_RD_ACK;
                        r_sda_oe <= 1'b0;
                        r_addr   <= r_addr + AWIDTH'(1);
                     end else begin
                        r_sda_oe <= ~r_shreg[6];
                        r_shreg  <= {r_shreg[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt + 4'd1;
                     end
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise) begin
                     r_rd_nack <= w_sda;
                  end else if (w_scl_fall) begin
                     if (!r_rd_nack) begin
                        r_state  <= S_RD_BYTE;
                        r_shreg  <= Reg_rdata;
                        r_sda_oe <= ~Reg_rdata[7];
                        r_bitcnt <= 4'd1;
                     end else begin
                        r_state  <= S_WAIT;
                        r_sda_oe <= 1'b0;
                     end
                  end
               end
               S_WAIT: begin
                  r_sda_oe <= 1'b0;
               end
               default: begin
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Sda_oe    = r_sda_oe;
   assign Reg_addr  = r_addr;
   assign Reg_wdata = r_wdata;
   assign Reg_wr    = r_wr;
   assign Busy      = r_busy;
   assign Addressed = r_addressed;

endmodule
